// File: rtl/decode_hazard_scoreboard_pkg.sv
// Shared decode definitions for the hazard scoreboard: opcode constants, field
// typedefs and the per-opcode source/destination usage rules.
package decode_hazard_scoreboard_pkg;

    typedef logic [4:0]  reg_tag_t;
    typedef logic [31:0] word_t;
    typedef logic [6:0]  opcode_t;

    localparam int NUM_REGS = 32;

    localparam opcode_t OP_REG    = 7'b0110011;
    localparam opcode_t OP_IMM    = 7'b0010011;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;

    function automatic logic op_reads_rs1(input opcode_t op);
        case (op)
            OP_REG, OP_BRANCH, OP_STORE, OP_IMM, OP_JALR, OP_LOAD: op_reads_rs1 = 1'b1;
            default:                                              op_reads_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic op_reads_rs2(input opcode_t op);
        case (op)
            OP_REG, OP_BRANCH, OP_STORE: op_reads_rs2 = 1'b1;
            default:                     op_reads_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic op_writes_rd(input opcode_t op);
        case (op)
            OP_REG, OP_IMM, OP_JAL, OP_JALR, OP_LOAD: op_writes_rd = 1'b1;
            default:                                  op_writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_hazard_scoreboard_counter.sv
// One register's countdown: decrements toward zero, can be raised to a new
// latency (the longer wait wins), and freezes while the pipe is held.
module scoreboard_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] dec;

    always_comb begin
        dec = (count == '0) ? '0 : count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!hold) begin
            count <= (load && (load_val > dec)) ? load_val : dec;
        end
    end

endmodule

// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage hazard scheduler: stalls the decoder while a source register of
// the instruction in decode still has a non-forwardable producer in flight.
module decode_hazard_scoreboard
    import decode_hazard_scoreboard_pkg::*;
#(
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] line,
    input  logic        line_valid,
    input  logic        ext_stall,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic [31:0] stall_cycles
);

    if ((ALU_LAT >= (1 << CNT_W)) || (LOAD_LAT >= (1 << CNT_W))) begin : g_lat_check
        $error("ALU_LAT and LOAD_LAT must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] ALU_LAT_C  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);

    opcode_t  op;
    reg_tag_t rs1;
    reg_tag_t rs2;
    reg_tag_t rd;
    logic     unused_fields;

    assign op            = line[6:0];
    assign rd            = line[11:7];
    assign rs1           = line[19:15];
    assign rs2           = line[24:20];
    assign unused_fields = ^{line[31:25], line[14:12]};

    // Entry 0 is a constant zero so x0 can never look pending.
    logic [CNT_W-1:0] cnt [NUM_REGS];
    assign cnt[0] = '0;

    logic rs1_busy;
    logic rs2_busy;
    logic hazard;
    logic set_dest;
    logic [CNT_W-1:0] dest_lat;

    always_comb begin
        rs1_busy = op_reads_rs1(op) && (rs1 != '0) && (cnt[rs1] != '0);
        rs2_busy = op_reads_rs2(op) && (rs2 != '0) && (cnt[rs2] != '0);
        hazard   = line_valid && !flush && (rs1_busy || rs2_busy);
        stall    = ext_stall || hazard;
        issue    = line_valid && !stall && !flush;
        set_dest = issue && op_writes_rd(op) && (rd != '0);
        dest_lat = (op == OP_LOAD) ? LOAD_LAT_C : ALU_LAT_C;
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        scoreboard_counter #(
            .CNT_W(CNT_W)
        ) u_counter (
            .clock   (clock),
            .reset_n (reset_n),
            .hold    (ext_stall),
            .load    (set_dest && (rd == reg_tag_t'(r))),
            .load_val(dest_lat),
            .count   (cnt[r])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (hazard && !ext_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Bench for decode_hazard_scoreboard: directed scenarios plus random traffic,
// checked against a ready-time model of register availability.
module tb_decode_hazard_scoreboard;

    localparam int ALU_LAT  = 0;
    localparam int LOAD_LAT = 2;
    localparam int CNT_W    = 3;

    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] line = 32'd0;
    logic        line_valid = 1'b0;
    logic        ext_stall = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        issue;
    logic [31:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    // Model: each register becomes forwardable at a back-end time; back-end time
    // advances on every non-frozen edge.
    longint      avail [32];
    longint      btime = 0;
    logic [31:0] m_cnt = 32'd0;

    logic        exp_stall, exp_issue, exp_hazard;
    logic        act_stall, act_issue;
    logic [31:0] exp_cnt, act_cnt;

    decode_hazard_scoreboard #(
        .ALU_LAT (ALU_LAT),
        .LOAD_LAT(LOAD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .line        (line),
        .line_valid  (line_valid),
        .ext_stall   (ext_stall),
        .flush       (flush),
        .stall       (stall),
        .issue       (issue),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        mk = {7'b0000000, rs2, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [1:0] src_use(input logic [6:0] op);
        if (op == OPC_REG || op == OPC_BRANCH || op == OPC_STORE) src_use = 2'b11;
        else if (op == OPC_IMM || op == OPC_JALR || op == OPC_LOAD) src_use = 2'b01;
        else src_use = 2'b00;
    endfunction

    function automatic logic writes(input logic [6:0] op);
        writes = (op == OPC_REG) || (op == OPC_IMM) || (op == OPC_JAL) ||
                 (op == OPC_JALR) || (op == OPC_LOAD);
    endfunction

    function automatic logic pend(input logic [4:0] r);
        pend = (r != 5'd0) && (avail[r] > btime);
    endfunction

    // Drive one cycle; sample at the falling edge, then advance the model at the rising edge.
    task automatic cycle(input logic [31:0] l, input logic v, input logic e,
                         input logic f, input logic rn);
        logic [1:0]  u;
        longint      ready;
        line = l; line_valid = v; ext_stall = e; flush = f; reset_n = rn;
        @(negedge clock);
        u          = src_use(l[6:0]);
        exp_hazard = v && !f && ((u[0] && pend(l[19:15])) || (u[1] && pend(l[24:20])));
        exp_stall  = e || exp_hazard;
        exp_issue  = v && !exp_stall && !f;
        exp_cnt    = m_cnt;
        act_stall  = stall;
        act_issue  = issue;
        act_cnt    = stall_cycles;
        @(posedge clock);
        if (!rn) begin
            for (int r = 0; r < 32; r++) avail[r] = 0;
            m_cnt = 32'd0;
        end else if (!e) begin
            if (exp_issue && writes(l[6:0]) && l[11:7] != 5'd0) begin
                ready = btime + ((l[6:0] == OPC_LOAD) ? LOAD_LAT : ALU_LAT) + 1;
                if (ready > avail[l[11:7]]) avail[l[11:7]] = ready;
            end
            btime = btime + 1;
            if (exp_hazard && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(mk(OPC_REG, 5'd3, 5'd1, 5'd2), 1'b1, logic'(i % 2), 1'b0, 1'b0);
            checks++;
            if (act_stall !== logic'(i % 2) || act_issue !== exp_issue) begin
                failures++;
                $display("FAIL reset_stall: got stall=%b issue=%b want stall=%b issue=%b",
                         act_stall, act_issue, logic'(i % 2), exp_issue);
            end
            checks++;
            if (act_cnt !== 32'd0) begin
                failures++;
                $display("FAIL reset_stall_cycles: got %0d want 0", act_cnt);
            end
        end
    endtask

    task automatic test_load_use();
        int waits = 0;
        bit issued = 0;
        cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(mk(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (act_stall !== 1'b0 || act_issue !== 1'b1) begin
            failures++;
            $display("FAIL load_issue: got stall=%b issue=%b want 0 1", act_stall, act_issue);
        end
        for (int k = 0; k < 8 && !issued; k++) begin
            cycle(mk(OPC_REG, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (act_stall !== exp_stall || act_issue !== exp_issue || act_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL load_use_cycle: got stall=%b issue=%b cnt=%0d want %b %b %0d",
                         act_stall, act_issue, act_cnt, exp_stall, exp_issue, exp_cnt);
            end
            if (act_issue === 1'b1) issued = 1;
            else waits++;
        end
        checks++;
        if (!issued || waits != 2) begin
            failures++;
            $display("FAIL load_use_latency: got issued=%0d waits=%0d want 1 2", issued, waits);
        end
        cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (act_cnt !== 32'd2) begin
            failures++;
            $display("FAIL load_use_stall_cycles: got %0d want 2", act_cnt);
        end
    endtask

    task automatic test_alu_no_stall();
        logic [31:0] seq [8];
        seq[0] = mk(OPC_IMM, 5'd5, 5'd0, 5'd0);
        seq[1] = mk(OPC_REG, 5'd6, 5'd5, 5'd5);
        seq[2] = mk(OPC_REG, 5'd7, 5'd6, 5'd5);
        seq[3] = mk(OPC_IMM, 5'd7, 5'd7, 5'd0);
        seq[4] = mk(OPC_JALR, 5'd8, 5'd7, 5'd0);
        seq[5] = mk(OPC_STORE, 5'd0, 5'd8, 5'd7);
        seq[6] = mk(OPC_BRANCH, 5'd0, 5'd8, 5'd6);
        seq[7] = mk(OPC_REG, 5'd9, 5'd8, 5'd8);
        for (int i = 0; i < 8; i++) begin
            cycle(seq[i], 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (act_stall !== 1'b0 || act_issue !== 1'b1 || act_stall !== exp_stall) begin
                failures++;
                $display("FAIL alu_no_stall[%0d]: got stall=%b issue=%b want 0 1",
                         i, act_stall, act_issue);
            end
        end
    endtask

    task automatic test_x0_and_jal();
        logic [31:0] seq [4];
        seq[0] = mk(OPC_LOAD, 5'd0, 5'd2, 5'd0);
        seq[1] = mk(OPC_REG, 5'd1, 5'd0, 5'd0);
        seq[2] = mk(OPC_JAL, 5'd7, 5'd3, 5'd4);
        seq[3] = mk(OPC_JAL, 5'd8, 5'd7, 5'd7);
        for (int i = 0; i < 4; i++) begin
            cycle(seq[i], 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (act_stall !== 1'b0 || act_issue !== 1'b1 || act_issue !== exp_issue) begin
                failures++;
                $display("FAIL x0_jal[%0d]: got stall=%b issue=%b want 0 1",
                         i, act_stall, act_issue);
            end
        end
    endtask

    task automatic test_ext_stall_freeze();
        int waits = 0;
        bit issued = 0;
        cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(mk(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(mk(OPC_REG, 5'd6, 5'd5, 5'd1), 1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if (act_stall !== 1'b1 || act_issue !== 1'b0 || act_cnt !== 32'd0) begin
                failures++;
                $display("FAIL freeze_hold[%0d]: got stall=%b issue=%b cnt=%0d want 1 0 0",
                         i, act_stall, act_issue, act_cnt);
            end
        end
        for (int k = 0; k < 8 && !issued; k++) begin
            cycle(mk(OPC_REG, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (act_stall !== exp_stall || act_issue !== exp_issue) begin
                failures++;
                $display("FAIL freeze_release: got stall=%b issue=%b want %b %b",
                         act_stall, act_issue, exp_stall, exp_issue);
            end
            if (act_issue === 1'b1) issued = 1;
            else waits++;
        end
        cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (!issued || waits != 2 || act_cnt !== 32'd2) begin
            failures++;
            $display("FAIL freeze_total: got issued=%0d waits=%0d cnt=%0d want 1 2 2",
                     issued, waits, act_cnt);
        end
    endtask

    task automatic test_waw();
        int waits = 0;
        bit issued = 0;
        cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(mk(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(mk(OPC_LOAD, 5'd5, 5'd2, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (act_issue !== 1'b1) begin
            failures++;
            $display("FAIL waw_second_issue: got issue=%b want 1", act_issue);
        end
        for (int k = 0; k < 8 && !issued; k++) begin
            cycle(mk(OPC_REG, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (act_stall !== exp_stall || act_issue !== exp_issue) begin
                failures++;
                $display("FAIL waw_consumer: got stall=%b issue=%b want %b %b",
                         act_stall, act_issue, exp_stall, exp_issue);
            end
            if (act_issue === 1'b1) issued = 1;
            else waits++;
        end
        checks++;
        if (!issued || waits != 2) begin
            failures++;
            $display("FAIL waw_latency: got issued=%0d waits=%0d want 1 2", issued, waits);
        end
    endtask

    task automatic test_flush_and_reset();
        cycle(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(mk(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(mk(OPC_LOAD, 5'd9, 5'd5, 5'd0), 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (act_stall !== 1'b0 || act_issue !== 1'b0) begin
            failures++;
            $display("FAIL flush_squash: got stall=%b issue=%b want 0 0", act_stall, act_issue);
        end
        cycle(mk(OPC_REG, 5'd10, 5'd9, 5'd9), 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (act_stall !== 1'b0 || act_issue !== 1'b1) begin
            failures++;
            $display("FAIL flush_not_marked: got stall=%b issue=%b want 0 1", act_stall, act_issue);
        end
        cycle(mk(OPC_LOAD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(mk(OPC_REG, 5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (act_stall !== 1'b1 || act_stall !== exp_stall) begin
            failures++;
            $display("FAIL pre_reset_hazard: got stall=%b want 1", act_stall);
        end
        cycle(mk(OPC_REG, 5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_stall !== 1'b1 || act_cnt !== 32'd1) begin
            failures++;
            $display("FAIL reset_cycle: got stall=%b cnt=%0d want 1 1", act_stall, act_cnt);
        end
        cycle(mk(OPC_REG, 5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (act_stall !== 1'b0 || act_issue !== 1'b1 || act_cnt !== 32'd0) begin
            failures++;
            $display("FAIL post_reset: got stall=%b issue=%b cnt=%0d want 0 1 0",
                     act_stall, act_issue, act_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [8];
        logic [6:0]  op;
        logic [31:0] l;
        int          bad = 0;
        ops[0] = OPC_REG;  ops[1] = OPC_IMM;    ops[2] = OPC_LOAD; ops[3] = OPC_STORE;
        ops[4] = OPC_BRANCH; ops[5] = OPC_JAL; ops[6] = OPC_JALR; ops[7] = OPC_LOAD;
        for (int i = 0; i < 1500; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
            l  = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  3'($urandom), 5'($urandom_range(0, 7)), op};
            cycle(l, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) != 0));
            checks++;
            if (act_stall !== exp_stall || act_issue !== exp_issue || act_cnt !== exp_cnt) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got stall=%b issue=%b cnt=%0d want %b %b %0d",
                             i, act_stall, act_issue, act_cnt, exp_stall, exp_issue, exp_cnt);
                bad++;
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) avail[r] = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_load_use();
        test_alu_no_stall();
        test_x0_and_jal();
        test_ext_stall_freeze();
        test_waw();
        test_flush_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
